fighter_action_fsm: RTL and testbench
=====================================

Name: fighter_action_fsm

Overview:
Per-player action state machine. It drives the state, position and attack-type signals that the hit-detection block consumes, and it consumes that block's hit result back as stun. It converts buttons into movement, startup/active/recovery attack phases and stun. Two instances are used: player 1 faces right, player 2 faces left.

Parameters:
FACING_RIGHT, 1, 1: forward is increasing x; 0: forward is decreasing x
INIT_X, 100, reset x position (left edge of 64-px sprite)
X_MIN, 0, lowest legal pos_x
X_MAX, 576, highest legal pos_x (640-64)
FWD_SPEED, 3, px per frame moving forward
BWD_SPEED, 2, px per frame moving backward
ATK_STARTUP / ATK_ACTIVE / ATK_RECOVERY, 5 / 2 / 16, basic-attack phase lengths in frames
DIR_STARTUP / DIR_ACTIVE / DIR_RECOVERY, 4 / 3 / 15, directional-attack phase lengths in frames
STUN_FRAMES, 16, stun length in frames
KNOCKBACK_PX, 8, knockback distance (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-clk pulse per video frame; all state and position updates happen only on this pulse
btn_left  in  1  level, left button
btn_right  in  1  level, right button
btn_attack  in  1  level, attack button
hit_taken  in  1  level from the hit detector (opponent's hit flag); a rising edge means this player was hit
state  out  4  current state code
pos_x  out  10  sprite x position
attacking  out  1  basic-attack sequence in progress
dir_attacking  out  1  directional-attack sequence in progress

Behaviour:
- State codes:
  - IDLE=0, MOVE_FWD=1, MOVE_BWD=2
  - ATTACK_START=5, ATTACK_ACT=6, ATTACK_REC=7
  - STUN=8
  - All other codes are unreachable; if ever entered, go to IDLE on the next tick.
- Reset: state=IDLE, pos_x=INIT_X, attacking=0, dir_attacking=0, frame counter=0, all latches cleared. Takes effect immediately, including mid-attack or mid-stun.
- Edge latches (evaluated every clk):
  - btn_attack and hit_taken are registered each clk.
  - A rising edge sets atk_pend or hit_pend respectively.
  - Both latches are cleared on every frame_tick after evaluation, whether consumed or not.
  - Holding btn_attack never re-triggers an attack.
- Frame counter: 5-bit. On entry to a timed state it loads N-1. Each tick it decrements. The FSM leaves the state on the tick where the count is 0, so each timed state lasts exactly N ticks. All length parameters are >=1 and <=32.
- Tick priority (highest first):
  1. hit_pend, from any state: enter STUN, load STUN_FRAMES-1, clear attacking and dir_attacking. A hit while already in STUN restarts the count.
  2. atk_pend, only in IDLE/MOVE_FWD/MOVE_BWD: enter ATTACK_START.
     - If exactly one direction button is held, set dir_attacking=1 and use the DIR_* lengths.
     - Otherwise set attacking=1 and use the ATK_* lengths.
     - pos_x is not updated on this tick.
  3. Movement, in IDLE/MOVE_* only:
     - Exactly one of left/right held: map it to forward or backward via FACING_RIGHT, enter MOVE_FWD or MOVE_BWD, and add or subtract the speed from pos_x on the same tick.
     - Both or neither held: IDLE, position unchanged.
- Attack sequence: ATTACK_START → ATTACK_ACT → ATTACK_REC → IDLE. The attack flag stays set through all three phases and clears on the tick that enters IDLE. Buttons other than a hit are ignored.
- STUN → IDLE when its count expires. Buttons are ignored during STUN.
- Position arithmetic: 11-bit signed intermediate, clamped to [X_MIN, X_MAX]. No wrap-around.
- attacking and dir_attacking are never both 1.
- All outputs are registered.

Optional Feature:
KNOCKBACK_EN
- Defined: on the tick that enters STUN (including a re-hit during STUN), pos_x moves backward by KNOCKBACK_PX, clamped to [X_MIN, X_MAX].
- Undefined: pos_x is unchanged on stun entry; no knockback logic is synthesized.

Test Plan:
- P1 (FACING_RIGHT=1, INIT_X=100), hold btn_right 4 ticks -> pos_x 103,106,109,112; state=1 every tick.
- 1-clk btn_attack pulse in IDLE, no direction held -> state 5 for 5 ticks, 6 for 2 ticks, 7 for 16 ticks, then 0; attacking=1 for exactly 23 ticks; dir_attacking=0; holding btn_attack afterwards starts no new attack.
- btn_attack pressed while btn_right held -> dir_attacking=1; phases last 4/3/15 ticks; pos_x unchanged throughout.
- hit_taken rises during state 6 -> next tick state=8 and attacking=0; 16 ticks later state=0; with KNOCKBACK_EN, pos_x 112→104; without it, 112 unchanged.
- Clamping:
  - P1 at pos_x=1, hold btn_left -> pos_x=0, state=2.
  - P2 (FACING_RIGHT=0) at 575, hold btn_right -> pos_x=576, state=2.
  - P2 holding btn_left moves -3 per tick, state=1.
- Simultaneous events and reset:
  - hit_pend and atk_pend set in the same frame -> STUN wins; no attack afterwards.
  - reset asserted mid-stun -> same clk: state=0, pos_x=100, both attack flags 0.

Source files
------------

// File: rtl/fighter_action_fsm.sv
// fighter_action_fsm
//   Per-player action state machine. Turns buttons into movement, a
//   three-phase attack (startup/active/recovery) and stun, and feeds
//   state / position / attack flags to the hit detector.
//
//   Optional build macro: KNOCKBACK_EN -- when defined, entering STUN pushes
//   the sprite backward by KNOCKBACK_PX (clamped). When undefined, no
//   knockback logic exists.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   frame_tick    in   one-clk pulse per video frame; all state/position updates happen here
//   btn_left      in   left button (level)
//   btn_right     in   right button (level)
//   btn_attack    in   attack button (level, rising edge triggers)
//   hit_taken     in   hit flag from the hit detector (rising edge = this player hit)
//   state         out  [3:0] current state code
//   pos_x         out  [9:0] sprite x position (left edge)
//   attacking     out  basic attack in progress
//   dir_attacking out  directional attack in progress
module fighter_action_fsm #(
  parameter int FACING_RIGHT = 1,
  parameter int INIT_X       = 100,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 576,
  parameter int FWD_SPEED    = 3,
  parameter int BWD_SPEED    = 2,
  parameter int ATK_STARTUP  = 5,
  parameter int ATK_ACTIVE   = 2,
  parameter int ATK_RECOVERY = 16,
  parameter int DIR_STARTUP  = 4,
  parameter int DIR_ACTIVE   = 3,
  parameter int DIR_RECOVERY = 15,
  parameter int STUN_FRAMES  = 16,
  parameter int KNOCKBACK_PX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       hit_taken,
  output logic [3:0] state,
  output logic [9:0] pos_x,
  output logic       attacking,
  output logic       dir_attacking
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_MOVE_FWD  = 4'd1,
    S_MOVE_BWD  = 4'd2,
    S_ATK_START = 4'd5,
    S_ATK_ACT   = 4'd6,
    S_ATK_REC   = 4'd7,
    S_STUN      = 4'd8
  } state_e;

  // Counter reload values: a state lasting N ticks loads N-1.
  localparam logic [4:0] ATK_S_LD  = 5'(ATK_STARTUP - 1);
  localparam logic [4:0] ATK_A_LD  = 5'(ATK_ACTIVE - 1);
  localparam logic [4:0] ATK_R_LD  = 5'(ATK_RECOVERY - 1);
  localparam logic [4:0] DIR_S_LD  = 5'(DIR_STARTUP - 1);
  localparam logic [4:0] DIR_A_LD  = 5'(DIR_ACTIVE - 1);
  localparam logic [4:0] DIR_R_LD  = 5'(DIR_RECOVERY - 1);
  localparam logic [4:0] STUN_LD   = 5'(STUN_FRAMES - 1);
  localparam logic [9:0] INIT_POS  = 10'(INIT_X);
  localparam logic [10:0] FWD_AMT  = 11'(FWD_SPEED);
  localparam logic [10:0] BWD_AMT  = 11'(BWD_SPEED);
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic FACE_R = (FACING_RIGHT != 0);

  // Move p by amt toward increasing x (up=1) or decreasing x, in signed
  // 11-bit arithmetic, and clamp to the legal range so it never wraps.
  function automatic logic [9:0] step_pos(input logic [9:0] p,
                                          input logic [10:0] amt,
                                          input logic up);
    logic signed [10:0] v;
    if (up) begin
      v = $signed({1'b0, p}) + $signed(amt);
    end else begin
      v = $signed({1'b0, p}) - $signed(amt);
    end
    if (v < XMIN_S) begin
      return XMIN_S[9:0];
    end else if (v > XMAX_S) begin
      return XMAX_S[9:0];
    end else begin
      return v[9:0];
    end
  endfunction

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [9:0] pos_q, pos_d;
  logic       attacking_q, attacking_d;
  logic       dir_attacking_q, dir_attacking_d;
  logic       btn_attack_q, btn_attack_d;
  logic       hit_taken_q, hit_taken_d;
  logic       atk_pend_q, atk_pend_d;
  logic       hit_pend_q, hit_pend_d;

  logic atk_now_s, hit_now_s;
  logic right_only_s, left_only_s, one_dir_s, fwd_held_s, bwd_held_s;

  // Edge latches: a press arriving on the tick clock itself is still seen
  // (atk_now/hit_now include the live edge) and then the latch clears.
  always_comb begin
    btn_attack_d = btn_attack;
    hit_taken_d  = hit_taken;
    atk_now_s    = atk_pend_q | (btn_attack & ~btn_attack_q);
    hit_now_s    = hit_pend_q | (hit_taken & ~hit_taken_q);
    if (frame_tick) begin
      atk_pend_d = 1'b0;
      hit_pend_d = 1'b0;
    end else begin
      atk_pend_d = atk_now_s;
      hit_pend_d = hit_now_s;
    end
  end

  // Direction decode relative to facing.
  always_comb begin
    right_only_s = btn_right & ~btn_left;
    left_only_s  = btn_left & ~btn_right;
    one_dir_s    = right_only_s | left_only_s;
    fwd_held_s   = FACE_R ? right_only_s : left_only_s;
    bwd_held_s   = FACE_R ? left_only_s : right_only_s;
  end

  // Next-state, counter, position and attack-flag logic, evaluated per tick.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pos_d           = pos_q;
    attacking_d     = attacking_q;
    dir_attacking_d = dir_attacking_q;
    if (frame_tick) begin
      if (hit_now_s) begin
        state_d         = S_STUN;
        cnt_d           = STUN_LD;
        attacking_d     = 1'b0;
        dir_attacking_d = 1'b0;
`ifdef KNOCKBACK_EN
        // Backward is away from the facing direction.
        pos_d = step_pos(pos_q, 11'(KNOCKBACK_PX), ~FACE_R);
`else
        pos_d = pos_q;
`endif
      end else begin
        case (state_q)
          S_IDLE, S_MOVE_FWD, S_MOVE_BWD: begin
            if (atk_now_s) begin
              state_d = S_ATK_START;
              if (one_dir_s) begin
                dir_attacking_d = 1'b1;
                cnt_d           = DIR_S_LD;
              end else begin
                attacking_d = 1'b1;
                cnt_d       = ATK_S_LD;
              end
            end else if (fwd_held_s) begin
              state_d = S_MOVE_FWD;
              pos_d   = step_pos(pos_q, FWD_AMT, FACE_R);
            end else if (bwd_held_s) begin
              state_d = S_MOVE_BWD;
              pos_d   = step_pos(pos_q, BWD_AMT, ~FACE_R);
            end else begin
              state_d = S_IDLE;
            end
          end
          S_ATK_START: begin
            if (cnt_q == 5'd0) begin
              state_d = S_ATK_ACT;
              cnt_d   = dir_attacking_q ? DIR_A_LD : ATK_A_LD;
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
          S_ATK_ACT: begin
            if (cnt_q == 5'd0) begin
              state_d = S_ATK_REC;
              cnt_d   = dir_attacking_q ? DIR_R_LD : ATK_R_LD;
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
          S_ATK_REC: begin
            if (cnt_q == 5'd0) begin
              state_d         = S_IDLE;
              attacking_d     = 1'b0;
              dir_attacking_d = 1'b0;
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
          S_STUN: begin
            if (cnt_q == 5'd0) begin
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
          default: begin
            state_d         = S_IDLE;
            cnt_d           = 5'd0;
            attacking_d     = 1'b0;
            dir_attacking_d = 1'b0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, position, flag and edge-latch registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= 5'd0;
      pos_q           <= INIT_POS;
      attacking_q     <= 1'b0;
      dir_attacking_q <= 1'b0;
      btn_attack_q    <= 1'b0;
      hit_taken_q     <= 1'b0;
      atk_pend_q      <= 1'b0;
      hit_pend_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pos_q           <= pos_d;
      attacking_q     <= attacking_d;
      dir_attacking_q <= dir_attacking_d;
      btn_attack_q    <= btn_attack_d;
      hit_taken_q     <= hit_taken_d;
      atk_pend_q      <= atk_pend_d;
      hit_pend_q      <= hit_pend_d;
    end
  end

  assign state         = state_q;
  assign pos_x         = pos_q;
  assign attacking     = attacking_q;
  assign dir_attacking = dir_attacking_q;

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Directed testbench for fighter_action_fsm: player-1 instance plus two
// small instances (P1 starting at x=1, P2 facing left at x=575) for clamping.
module tb_fighter_action_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic l1 = 1'b0, r1 = 1'b0, a1 = 1'b0, h1 = 1'b0;
  logic l2 = 1'b0, r2 = 1'b0, zero = 1'b0;

  logic [3:0] st1, stc, st2;
  logic [9:0] px1, pxc, px2;
  logic at1, da1, atc, dac, at2, da2;

  int errors = 0;
  int checks = 0;
  int exp_pos;
  int kb;

  always #5 clk = ~clk;

  fighter_action_fsm u_p1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_left(l1), .btn_right(r1), .btn_attack(a1), .hit_taken(h1),
    .state(st1), .pos_x(px1), .attacking(at1), .dir_attacking(da1));

  fighter_action_fsm #(.FACING_RIGHT(1), .INIT_X(1)) u_p1c (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_left(l2), .btn_right(r2), .btn_attack(zero), .hit_taken(zero),
    .state(stc), .pos_x(pxc), .attacking(atc), .dir_attacking(dac));

  fighter_action_fsm #(.FACING_RIGHT(0), .INIT_X(575)) u_p2 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_left(l2), .btn_right(r2), .btn_attack(zero), .hit_taken(zero),
    .state(st2), .pos_x(px2), .attacking(at2), .dir_attacking(da2));

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One frame tick; returns at the following falling edge, after the update.
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef KNOCKBACK_EN
    kb = 8;
`else
    kb = 0;
`endif
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", st1, 0);
    check("rst_pos", px1, 100);
    check("rst_atk", at1, 0);
    check("rst_dir", da1, 0);
    reset = 1'b0;
    @(negedge clk);

    // Walk forward 4 ticks
    r1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("walk_pos", px1, 100 + 3 * i);
      check("walk_state", st1, 1);
    end
    r1 = 1'b0;
    tick();
    check("stop_state", st1, 0);
    check("stop_pos", px1, 112);

    // Basic attack from a 1-clk pulse: 5/2/16 ticks
    a1 = 1'b1;
    @(negedge clk);
    a1 = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      tick();
      check("atk_state", st1, (i <= 5) ? 5 : ((i <= 7) ? 6 : 7));
      check("atk_flag", at1, 1);
      check("atk_dir", da1, 0);
    end
    tick();
    check("atk_end_state", st1, 0);
    check("atk_end_flag", at1, 0);

    // Directional attack with right held: 4/3/15 ticks, no movement
    r1 = 1'b1;
    a1 = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      check("dir_state", st1, (i <= 4) ? 5 : ((i <= 7) ? 6 : 7));
      check("dir_flag", da1, 1);
      check("dir_atk", at1, 0);
      check("dir_pos", px1, 112);
    end
    tick();
    check("dir_end_state", st1, 0);
    check("dir_end_flag", da1, 0);
    check("dir_end_pos", px1, 112);
    // Attack still held: no re-trigger
    r1 = 1'b0;
    tick();
    tick();
    check("hold_state", st1, 0);
    check("hold_atk", at1, 0);
    a1 = 1'b0;
    @(negedge clk);

    // Hit during the active phase
    a1 = 1'b1;
    @(negedge clk);
    a1 = 1'b0;
    repeat (6) tick();
    check("pre_hit_state", st1, 6);
    h1 = 1'b1;
    @(negedge clk);
    tick();
    exp_pos = 112 - kb;
    check("hit_state", st1, 8);
    check("hit_atk", at1, 0);
    check("hit_pos", px1, exp_pos);
    repeat (15) tick();
    check("stun_last", st1, 8);
    tick();
    check("stun_exit", st1, 0);
    h1 = 1'b0;
    @(negedge clk);

    // Hit and attack in the same frame: stun wins
    a1 = 1'b1;
    h1 = 1'b1;
    @(negedge clk);
    a1 = 1'b0;
    tick();
    exp_pos = exp_pos - kb;
    check("sim_state", st1, 8);
    check("sim_atk", at1, 0);
    check("sim_dir", da1, 0);
    check("sim_pos", px1, exp_pos);
    repeat (16) tick();
    check("sim_exit", st1, 0);
    tick();
    check("sim_no_atk_state", st1, 0);
    check("sim_no_atk_flag", at1, 0);
    h1 = 1'b0;
    @(negedge clk);

    // Reset mid-stun takes effect immediately
    h1 = 1'b1;
    @(negedge clk);
    tick();
    check("stun2_state", st1, 8);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("rst_mid_state", st1, 0);
    check("rst_mid_pos", px1, 100);
    check("rst_mid_atk", at1, 0);
    check("rst_mid_dir", da1, 0);
    h1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Both directions held: idle, no move
    l1 = 1'b1;
    r1 = 1'b1;
    tick();
    check("both_state", st1, 0);
    check("both_pos", px1, 100);
    l1 = 1'b0;
    r1 = 1'b0;

    // Clamping: P2 backward to X_MAX, P1c forward
    r2 = 1'b1;
    tick();
    check("p2_clamp_pos", px2, 576);
    check("p2_clamp_state", st2, 2);
    check("p1c_fwd_pos", pxc, 4);
    r2 = 1'b0;
    l2 = 1'b1;
    tick();
    check("p2_fwd_pos", px2, 573);
    check("p2_fwd_state", st2, 1);
    check("p1c_bwd_pos", pxc, 2);
    tick();
    check("p1c_zero_pos", pxc, 0);
    check("p1c_zero_state", stc, 2);
    tick();
    check("p1c_hold_pos", pxc, 0);
    check("p2_fwd2_pos", px2, 567);
    l2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
